reg_delay_var: RTL and testbench

Parametrised, runtime-selectable pipeline delay line that supersedes the fixed 8-stage register chains used to align operands and residue digits across the TPU datapath. It carries `LANES` parallel data words with a shared valid bit and a clock enable for stalls. The delay is selectable at run time from 1 to `MAX_DEPTH` cycles. After a delay change, output-valid is masked until the line has refilled, so downstream modular arithmetic never consumes duplicated or stale digits.

---
 rtl/reg_delay_pkg.sv | 21 ++
 rtl/reg_delay_stage.sv | 41 ++++
 rtl/reg_delay_var.sv | 103 ++++++++++
 tb/tb_reg_delay_var.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_delay_pkg.sv
// Shared helpers for the runtime-selectable delay line.
package reg_delay_pkg;

    // Width needed to encode a delay in 0..max_depth.
    function automatic int unsigned delay_w(input int unsigned max_depth);
        return $clog2(max_depth + 1);
    endfunction

    // Map a requested delay onto the legal range 1..max_depth.
    function automatic int unsigned clamp_delay(input int unsigned sel,
                                                input int unsigned max_depth);
        if (sel == 0) begin
            return 1;
        end else if (sel > max_depth) begin
            return max_depth;
        end else begin
            return sel;
        end
    endfunction

endpackage

// File: rtl/reg_delay_stage.sv
// One {valid, data} register stage of the delay line, frozen when ce is low.
module reg_delay_stage #(
    parameter int unsigned WIDTH = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;

    // Load from the previous stage on enabled cycles, hold otherwise.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (ce) begin
            valid_d = in_valid;
            data_d  = in_data;
        end
    end

    // Stage register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/reg_delay_var.sv
// Multi-lane delay line with a runtime-selectable tap and output masking while
// the line refills after a delay change.
module reg_delay_var
    import reg_delay_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 18,
    parameter int unsigned LANES         = 1,
    parameter int unsigned MAX_DEPTH     = 8,
    parameter int unsigned DEFAULT_DELAY = 8,
    localparam int unsigned DW           = delay_w(MAX_DEPTH),
    localparam int unsigned W            = LANES * DATA_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    input  logic [DW-1:0] delay_sel,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    output logic [DW-1:0] delay_active,
    output logic          settling
);

    // Index 0 is the input; index k is the output of physical stage k.
    logic         stage_valid [MAX_DEPTH+1];
    logic [W-1:0] stage_data  [MAX_DEPTH+1];

    assign stage_valid[0] = in_valid;
    assign stage_data[0]  = in_data;

    for (genvar k = 1; k <= MAX_DEPTH; k++) begin : g_stage
        reg_delay_stage #(
            .WIDTH (W)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .ce        (ce),
            .in_valid  (stage_valid[k-1]),
            .in_data   (stage_data[k-1]),
            .out_valid (stage_valid[k]),
            .out_data  (stage_data[k])
        );
    end

    logic [DW-1:0] sel_clamped;
    logic [DW-1:0] active_d, active_q;
    logic [DW-1:0] settle_d, settle_q;
    logic          change;

    // Clamp the requested delay into 1..MAX_DEPTH.
    always_comb begin
        sel_clamped = DW'(clamp_delay(int'(delay_sel), MAX_DEPTH));
    end

    // Track delay changes and count enabled edges until the tap holds a post-change word.
    always_comb begin
        active_d = active_q;
        settle_d = settle_q;
        change   = (sel_clamped != active_q);
        if (change) begin
            active_d = sel_clamped;
            settle_d = sel_clamped;
        end
        // An enabled change edge already moves the word it accepts into stage 1,
        // so it counts as the first refill step.
        if (ce && settle_d != '0) begin
            settle_d = settle_d - 1'b1;
        end
    end

    // Delay and settle-counter registers; reset wins over ce and delay changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= DW'(DEFAULT_DELAY);
            settle_q <= '0;
        end else begin
            active_q <= active_d;
            settle_q <= settle_d;
        end
    end

    logic         tap_valid;
    logic [W-1:0] tap_data;

    // Output tap mux selecting stage delay_active.
    always_comb begin
        tap_valid = stage_valid[1];
        tap_data  = stage_data[1];
        for (int unsigned k = 1; k <= MAX_DEPTH; k++) begin
            if (active_q == DW'(k)) begin
                tap_valid = stage_valid[k];
                tap_data  = stage_data[k];
            end
        end
    end

    assign settling     = (settle_q != '0);
    assign out_valid    = tap_valid & ~settling;
    assign out_data     = tap_data;
    assign delay_active = active_q;

endmodule

// File: tb/tb_reg_delay_var.sv
// Scoreboard bench for reg_delay_var: stimulus pushes expected words with the
// enabled-edge count at which they must appear; a monitor pops and compares.
module tb_reg_delay_var;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, ce, in_valid;
    logic [17:0] in_data;
    logic [3:0]  delay_sel;
    logic        out_valid, settling;
    logic [17:0] out_data;
    logic [3:0]  delay_active;

    reg_delay_var #(
        .DATA_WIDTH    (18),
        .LANES         (1),
        .MAX_DEPTH     (8),
        .DEFAULT_DELAY (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ce           (ce),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .delay_sel    (delay_sel),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .delay_active (delay_active),
        .settling     (settling)
    );

    logic        l_in_valid, l_out_valid, l_settling;
    logic [19:0] l_in_data, l_out_data;
    logic [2:0]  l_delay_sel, l_delay_active;

    reg_delay_var #(
        .DATA_WIDTH    (5),
        .LANES         (4),
        .MAX_DEPTH     (4),
        .DEFAULT_DELAY (2)
    ) dut_lanes (
        .clk          (clk),
        .reset        (reset),
        .ce           (ce),
        .in_valid     (l_in_valid),
        .in_data      (l_in_data),
        .delay_sel    (l_delay_sel),
        .out_valid    (l_out_valid),
        .out_data     (l_out_data),
        .delay_active (l_delay_active),
        .settling     (l_settling)
    );

    typedef struct {
        logic [17:0] data;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned en_edges = 0;
    int unsigned cur_d = 8;
    logic        adv = 1'b0;

    // Count enabled (non-reset) edges; adv marks that the last edge advanced the line.
    always @(posedge clk) begin
        adv <= ce && !reset;
        if (!reset && ce) en_edges <= en_edges + 1;
    end

    // Monitor: every freshly presented valid word must match the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (adv && out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got %h with out_valid=1, required no output",
                         out_data);
            end else begin
                e = sb.pop_front();
                if (out_data !== e.data || en_edges != e.due) begin
                    errors++;
                    $display("FAIL word: got %h at edge %0d, required %h at edge %0d",
                             out_data, en_edges, e.data, e.due);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // Present one input on an enabled edge; optionally expect it at the output.
    task automatic send(input logic [17:0] v, input bit valid, input bit expect_out);
        exp_t e;
        in_data  = v;
        in_valid = valid;
        ce       = 1'b1;
        if (valid && expect_out) begin
            e.data = v;
            e.due  = en_edges + cur_d;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++) send(18'h0, 1'b0, 1'b0);
    endtask

    // Hold ce low and confirm the output does not move.
    task automatic stall(input int n);
        logic [17:0] held_data;
        logic        held_valid;
        held_data  = out_data;
        held_valid = out_valid;
        ce = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("stall_data_frozen", 32'(out_data), 32'(held_data));
            check("stall_valid_frozen", 32'(out_valid), 32'(held_valid));
        end
    endtask

    initial begin
        logic [19:0] lane_exp;

        reset = 1'b1; ce = 1'b0; in_valid = 1'b0; in_data = '0; delay_sel = 4'd8;
        l_in_valid = 1'b0; l_in_data = '0; l_delay_sel = 3'd2;
        repeat (2) @(negedge clk);

        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_settling", 32'(settling), 32'd0);
        check("reset_delay_active", 32'(delay_active), 32'd8);
        check("reset_lane_valid", 32'(l_out_valid), 32'd0);
        reset = 1'b0;

        // Default delay 8: values 1..12 back to back.
        cur_d = 8;
        for (int i = 1; i <= 12; i++) send(18'(i), 1'b1, 1'b1);
        bubbles(10);

        // Delay 3 with a 4-cycle stall in the middle of the stream.
        delay_sel = 4'd3; cur_d = 3;
        send(18'h0, 1'b0, 1'b0);
        check("change_to_3_active", 32'(delay_active), 32'd3);
        check("change_to_3_settling", 32'(settling), 32'd1);
        bubbles(3);
        for (int i = 0; i < 8; i++) send(18'(8'hA0 + i), 1'b1, 1'b1);
        stall(4);
        for (int i = 8; i < 16; i++) send(18'(8'hA0 + i), 1'b1, 1'b1);
        bubbles(5);

        // Back to 8, then 8 -> 2 mid-stream; word 0x105 rides the change edge.
        delay_sel = 4'd8; cur_d = 8;
        bubbles(10);
        for (int i = 0; i < 5; i++) send(18'h100 + 18'(i), 1'b1, 1'b0);
        delay_sel = 4'd2; cur_d = 2;
        send(18'h105, 1'b1, 1'b1);
        check("change_8_2_settling", 32'(settling), 32'd1);
        check("change_8_2_masked", 32'(out_valid), 32'd0);
        check("change_8_2_active", 32'(delay_active), 32'd2);
        send(18'h106, 1'b1, 1'b1);
        check("change_8_2_settled", 32'(settling), 32'd0);
        check("change_8_2_first_valid", 32'(out_valid), 32'd1);
        for (int i = 7; i < 12; i++) send(18'h100 + 18'(i), 1'b1, 1'b1);
        bubbles(4);

        // Clamping: 0 -> 1 and 15 -> 8.
        delay_sel = 4'd0; cur_d = 1;
        send(18'h0, 1'b0, 1'b0);
        check("clamp_low_active", 32'(delay_active), 32'd1);
        bubbles(2);
        for (int i = 0; i < 3; i++) send(18'h2A0 + 18'(i), 1'b1, 1'b1);
        bubbles(2);
        delay_sel = 4'd15; cur_d = 8;
        send(18'h0, 1'b0, 1'b0);
        check("clamp_high_active", 32'(delay_active), 32'd8);
        bubbles(9);
        for (int i = 0; i < 3; i++) send(18'h2B0 + 18'(i), 1'b1, 1'b1);
        bubbles(9);

        // Reset with five words in flight; none may ever emerge.
        delay_sel = 4'd8;
        for (int i = 0; i < 5; i++) send(18'h300 + 18'(i), 1'b1, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_out_data", 32'(out_data), 32'd0);
        check("midreset_settling", 32'(settling), 32'd0);
        check("midreset_delay_active", 32'(delay_active), 32'd8);
        reset = 1'b0;
        bubbles(12);

        // Lane independence on the 4x5-bit instance, delay 2.
        ce = 1'b1; in_valid = 1'b0;
        l_in_data = {5'h13, 5'h12, 5'h11, 5'h10}; l_in_valid = 1'b1;
        @(negedge clk);
        check("lanes_latency_not_yet", 32'(l_out_valid), 32'd0);
        l_in_data = {5'h0A, 5'h15, 5'h00, 5'h1F};
        @(negedge clk);
        l_in_valid = 1'b0; l_in_data = '0;
        check("lanes_p1_valid", 32'(l_out_valid), 32'd1);
        lane_exp = {5'h13, 5'h12, 5'h11, 5'h10};
        for (int i = 0; i < 4; i++)
            check($sformatf("lane%0d_p1", i), 32'(l_out_data[i*5 +: 5]), 32'(lane_exp[i*5 +: 5]));
        @(negedge clk);
        check("lanes_p2_valid", 32'(l_out_valid), 32'd1);
        lane_exp = {5'h0A, 5'h15, 5'h00, 5'h1F};
        for (int i = 0; i < 4; i++)
            check($sformatf("lane%0d_p2", i), 32'(l_out_data[i*5 +: 5]), 32'(lane_exp[i*5 +: 5]));
        @(negedge clk);
        check("lanes_drained", 32'(l_out_valid), 32'd0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
